// File: rtl/pkt_fifo_sync.sv
// pkt_fifo_sync: packet-aware synchronous FIFO with commit/rollback pointers.
// The reader only sees words of packets whose last beat has been accepted.
// An open packet is rolled back on explicit drop or when it overflows.
// Optional macro PKT_FIFO_STATS_EN enables the saturating drop_cnt counter.
module pkt_fifo_sync #(
  parameter int ADDR_WIDTH  = 11,
  parameter int W_EL        = 20,
  parameter int AFULL_LEVEL = 2**ADDR_WIDTH-16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [W_EL-1:0]       wdata,
  input  logic                  wen,
  input  logic                  wlast,
  input  logic                  wdrop,
  output logic                  full,
  output logic                  afull,
  input  logic                  ren,
  output logic [W_EL-1:0]       rdata,
  output logic                  rlast,
  output logic                  rvalid,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   level,
  output logic [15:0]           drop_cnt
);

  localparam logic [ADDR_WIDTH:0] DEPTH   = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] ONE     = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0] AFULL_L = AFULL_LEVEL[ADDR_WIDTH:0];

  typedef enum logic [1:0] {ST_IDLE, ST_PKT, ST_DISCARD} wr_state_t;

  wr_state_t           state, state_n;
  logic [ADDR_WIDTH:0] wptr, cptr, rptr;
  logic [ADDR_WIDTH:0] wptr_n, cptr_n;
  logic [ADDR_WIDTH:0] wptr_inc, used;
  logic                mem_we, drop_inc, rd_fire;

  logic [W_EL:0] mem [0:(2**ADDR_WIDTH)-1];

  // Status flags come from registered pointers only.
  assign used     = wptr - rptr;
  assign level    = cptr - rptr;
  assign empty    = (rptr == cptr);
  assign full     = (used == DEPTH);
  assign afull    = (used >= AFULL_L);
  assign wptr_inc = wptr + ONE;
  assign rd_fire  = ren && !empty;

  // Write FSM next state: accept, commit, or roll back the open packet.
  always_comb begin
    state_n  = state;
    wptr_n   = wptr;
    cptr_n   = cptr;
    mem_we   = 1'b0;
    drop_inc = 1'b0;
    case (state)
      ST_IDLE, ST_PKT: begin
        if (wdrop) begin
          // Drop wins over any same-cycle beat; in IDLE nothing is open.
          if (state == ST_PKT) begin
            wptr_n   = cptr;
            drop_inc = 1'b1;
          end
          state_n = ST_IDLE;
        end else if (wen && !full) begin
          mem_we = 1'b1;
          wptr_n = wptr_inc;
          if (wlast) begin
            cptr_n  = wptr_inc;
            state_n = ST_IDLE;
          end else begin
            state_n = ST_PKT;
          end
        end else if (wen) begin
          // Overflow: a last beat drops at once, otherwise swallow the rest.
          if (wlast) begin
            wptr_n   = cptr;
            drop_inc = 1'b1;
            state_n  = ST_IDLE;
          end else begin
            state_n = ST_DISCARD;
          end
        end
      end
      ST_DISCARD: begin
        if (wdrop || (wen && wlast)) begin
          wptr_n   = cptr;
          drop_inc = 1'b1;
          state_n  = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Write-side state and pointer registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      wptr  <= '0;
      cptr  <= '0;
    end else begin
      state <= state_n;
      wptr  <= wptr_n;
      cptr  <= cptr_n;
    end
  end

  // Storage array; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wptr[ADDR_WIDTH-1:0]] <= {wlast, wdata};
  end

  // Registered read port; rdata/rlast hold when no read fires.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rptr   <= '0;
      rvalid <= 1'b0;
      rdata  <= '0;
      rlast  <= 1'b0;
    end else begin
      rvalid <= rd_fire;
      if (rd_fire) begin
        {rlast, rdata} <= mem[rptr[ADDR_WIDTH-1:0]];
        rptr           <= rptr + ONE;
      end
    end
  end

`ifdef PKT_FIFO_STATS_EN
  // Saturating count of dropped packets.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                           drop_cnt <= '0;
    else if (drop_inc && drop_cnt != '1)    drop_cnt <= drop_cnt + 16'd1;
  end
`else
  logic unused_drop_inc;
  assign unused_drop_inc = drop_inc;
  assign drop_cnt        = '0;
`endif

endmodule

// File: tb/tb_pkt_fifo_sync.sv
// Bench for pkt_fifo_sync at depth 16: directed packet scenarios plus random
// traffic, checked against a queue-based model of committed/pending packets.
module tb_pkt_fifo_sync;
  localparam int AW    = 4;
  localparam int W     = 20;
  localparam int DEPTH = 2**AW;
  localparam int AFL   = 12;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [W-1:0]  wdata;
  logic          wen, wlast, wdrop, ren;
  logic          full, afull, rlast, rvalid, empty;
  logic [W-1:0]  rdata;
  logic [AW:0]   level;
  logic [15:0]   drop_cnt;

  pkt_fifo_sync #(.ADDR_WIDTH(AW), .W_EL(W), .AFULL_LEVEL(AFL)) dut (
    .clk(clk), .reset_n(reset_n), .wdata(wdata), .wen(wen), .wlast(wlast),
    .wdrop(wdrop), .full(full), .afull(afull), .ren(ren), .rdata(rdata),
    .rlast(rlast), .rvalid(rvalid), .empty(empty), .level(level),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: committed unread words, words of the open packet, expected reads.
  logic [W:0] cq[$];
  logic [W:0] pq[$];
  logic [W:0] expq[$];
  bit         disc;
  int         drops;
  bit         exp_rvalid;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int exp_drop();
`ifdef PKT_FIFO_STATS_EN
    return (drops > 65535) ? 65535 : drops;
`else
    return 0;
`endif
  endfunction

  // Scoreboard monitor: every valid read word must match the oldest expectation.
  always @(negedge clk) begin
    if (reset_n && rvalid) begin
      if (expq.size() == 0) begin
        chk("rd_unexpected", 32'(rvalid), 32'd0);
      end else begin
        logic [W:0] e;
        e = expq.pop_front();
        chk("rdata", 32'(rdata), 32'(e[W-1:0]));
        chk("rlast", 32'(rlast), 32'(e[W]));
      end
    end
  end

  task automatic check_flags();
    chk("level", 32'(level), 32'(cq.size()));
    chk("empty", 32'(empty), 32'(cq.size() == 0));
    chk("full",  32'(full),  32'((cq.size() + pq.size()) == DEPTH));
    chk("afull", 32'(afull), 32'((cq.size() + pq.size()) >= AFL));
    chk("rvalid", 32'(rvalid), 32'(exp_rvalid));
    chk("drop_cnt", 32'(drop_cnt), 32'(exp_drop()));
  endtask

  // One clock of stimulus; the model advances using pre-edge occupancy.
  task automatic step(input bit we, input bit wl, input bit wd, input bit re,
                      input logic [W-1:0] d);
    bit is_full;
    wen = we; wlast = wl; wdrop = wd; ren = re; wdata = d;
    is_full = (cq.size() + pq.size()) == DEPTH;
    if (re && cq.size() > 0) begin
      expq.push_back(cq.pop_front());
      exp_rvalid = 1'b1;
    end else begin
      exp_rvalid = 1'b0;
    end
    if (!disc) begin
      if (wd) begin
        if (pq.size() > 0) begin pq.delete(); drops++; end
      end else if (we && !is_full) begin
        pq.push_back({wl, d});
        if (wl) begin
          foreach (pq[i]) cq.push_back(pq[i]);
          pq.delete();
        end
      end else if (we) begin
        if (wl) begin pq.delete(); drops++; end
        else disc = 1'b1;
      end
    end else if (wd || (we && wl)) begin
      pq.delete(); drops++; disc = 1'b0;
    end
    @(posedge clk); #1;
    check_flags();
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 0, '0);
  endtask

  task automatic drain(input int n);
    repeat (n) step(0, 0, 0, 1, '0);
  endtask

  task automatic wr_pkt(input int n);
    for (int i = 0; i < n; i++) step(1, i == n - 1, 0, 0, W'($urandom));
  endtask

  task automatic rand_phase(input int n, input int p_ren);
    for (int i = 0; i < n; i++)
      step($urandom_range(0, 99) < 60, $urandom_range(0, 7) == 0,
           $urandom_range(0, 39) == 0, $urandom_range(0, 99) < p_ren, W'($urandom));
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; wen = 0; wlast = 0; wdrop = 0; ren = 0; wdata = '0;
    disc = 0; drops = 0; exp_rvalid = 0;
    #12;
    chk("rst_rdata", 32'(rdata), 32'd0);
    chk("rst_rlast", 32'(rlast), 32'd0);
    check_flags();
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Three-word packet, then read it back.
    step(1, 0, 0, 0, W'('hA));
    step(1, 0, 0, 0, W'('hB));
    step(1, 1, 0, 0, W'('hC));
    drain(4);

    // Two words then an explicit drop; the next packet must be intact.
    step(1, 0, 0, 0, W'('h11));
    step(1, 0, 0, 0, W'('h22));
    step(0, 0, 1, 0, '0);
    wr_pkt(3);
    drain(4);

    // Overflow: 16 words without last, then more beats until last.
    for (int i = 0; i < 16; i++) step(1, 0, 0, 0, W'(i + 'h100));
    step(1, 0, 0, 0, W'('h200));
    step(1, 0, 0, 0, W'('h201));
    step(1, 0, 0, 1, W'('h202));
    step(1, 1, 0, 0, W'('h203));
    idle(2);

    // Fill and drain across the pointer wrap.
    for (int k = 0; k < 5; k++) begin
      wr_pkt(7);
      wr_pkt(7);
      drain(15);
    end

    // Last beat coinciding with drop in an open packet; drop while idle.
    step(1, 0, 0, 0, W'('h55));
    step(1, 1, 1, 0, W'('h56));
    step(0, 0, 1, 0, '0);
    step(1, 0, 1, 0, W'('h57));
    idle(2);

    // Random traffic: writer-heavy then reader-heavy.
    rand_phase(2500, 35);
    rand_phase(2500, 75);
    drain(DEPTH + 2);
    step(0, 0, 1, 0, '0);

    // Asynchronous reset in the middle of a read.
    wr_pkt(4);
    step(0, 0, 0, 1, '0);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_rvalid", 32'(rvalid), 32'd0);
    chk("arst_empty",  32'(empty),  32'd1);
    chk("arst_level",  32'(level),  32'd0);
    chk("arst_rdata",  32'(rdata),  32'd0);
    cq.delete(); pq.delete(); expq.delete();
    disc = 0; drops = 0; exp_rvalid = 0;
    #3 reset_n = 1'b1;
    @(posedge clk); #1;
    wr_pkt(2);
    drain(3);
    idle(2);

    chk("pending_reads", 32'(expq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pkt_fifo_sync.md
# pkt_fifo_sync

Packet-aware synchronous FIFO for the filter datapath: buffers `W_EL`-bit words tagged with an end-of-packet marker, exposes to the reader only words of fully committed packets, and rewinds the write pointer to discard a packet on explicit drop or on overflow. It sits between the ingress parser and the filter decision stage. It replaces ad-hoc pointer-reset use of the plain synchronous FIFO with an internal commit/rollback pointer pair.

## Interface
- `ADDR_WIDTH`, 11, log2 of depth; depth = 2**ADDR_WIDTH words.
- `W_EL`, 20, data width; storage is `W_EL+1` bits (data + last flag).
- `AFULL_LEVEL`, 2**ADDR_WIDTH-16, reserved-word count (written, unread) at or above which `afull` asserts.
- `clk` in 1, single clock; all logic on rising edge.
- `reset_n` in 1, asynchronous, active-low reset.
- `wdata` in W_EL, write word.
- `wen` in 1, write beat valid.
- `wlast` in 1, qualifies `wen` beat as last word of packet (commit).
- `wdrop` in 1, discard the packet in progress.
- `full` out 1, no free word (write pointer minus read pointer = depth).
- `afull` out 1, write pointer minus read pointer >= AFULL_LEVEL.
- `ren` in 1, read request.
- `rdata` out W_EL, read word, registered.
- `rlast` out 1, last flag of `rdata`.
- `rvalid` out 1, `rdata`/`rlast` valid this cycle.
- `empty` out 1, no committed unread word (read pointer = commit pointer).
- `level` out ADDR_WIDTH+1, committed unread words (commit pointer minus read pointer).
- `drop_cnt` out 16, dropped-packet count (see Configuration).

## Operation
- Pointers `wptr`, `cptr`, `rptr`, each ADDR_WIDTH+1 bits, modulo-2**(ADDR_WIDTH+1) arithmetic; low ADDR_WIDTH bits address memory; MSB disambiguates full/empty on wrap.
- Write FSM: IDLE (no packet open), PKT (packet open), DISCARD (overflowed packet, swallowing beats).
- IDLE/PKT, `wen && !full && !wdrop`: write `{wlast,wdata}` at `wptr`, `wptr+1`; if `wlast`, `cptr <= wptr+1` and go IDLE, else go PKT.
- `wen && full` in IDLE/PKT: beat not written; go DISCARD (even if `wlast`, which instead drops immediately: `wptr <= cptr`, count drop, go IDLE).
- DISCARD: all `wen` beats consumed, not written; on `wen && wlast`: `wptr <= cptr`, count drop, go IDLE.
- `wdrop` in PKT or DISCARD: `wptr <= cptr`, count drop, go IDLE; any same-cycle `wen` beat (with or without `wlast`) is discarded. `wdrop` in IDLE: no effect, not counted.
- Read: `ren && !empty`: read word at `rptr`, `rptr+1`; `rvalid` high next cycle. `ren && empty`: ignored, `rvalid` low next cycle.
- Reader never observes uncommitted or dropped words.

## Timing
- Reset (`reset_n` low, asynchronous): all pointers 0, FSM IDLE, `empty`=1, `full`=0, `afull`=0, `rvalid`=0, `rdata`=0, `rlast`=0, `level`=0, `drop_cnt`=0. Memory contents not reset. Reset mid-packet discards everything.
- `full`, `afull`, `empty`, `level` are derived from registered pointers only; no combinational path from inputs.
- Commit visibility: beat with `wlast` accepted at edge N; `empty` deasserts and `level` updates after edge N (visible in cycle N+1).
- Read latency 1: `ren` sampled at edge N, `rdata`/`rlast`/`rvalid` valid in cycle N+1; `rdata` holds last value when `rvalid`=0.
- `full` deasserts the cycle after a read at full; a write in the same cycle as that read is still an overflow (full sampled before the edge).
- Simultaneous read and commit: both apply; `level` = old + packet-remaining words − 1.
- Packet longer than depth can never commit and is always dropped.

## Configuration
- `PKT_FIFO_STATS_EN` defined: `drop_cnt` is a 16-bit saturating counter (holds at 16'hFFFF) incremented once per dropped packet (explicit `wdrop` or overflow).
- Not defined: counter absent, `drop_cnt` tied to 0.

## Test plan
- Reset, write 3-word packet A,B,C(wlast) -> `empty`=1 until cycle after C; then 3 reads give A,B,C with `rlast` only on C, `level` 3→0, `empty`=1.
- Write 2 words then `wdrop` -> `empty` stays 1, `wptr` back to `cptr`, `drop_cnt`=1; next packet reads back intact.
- ADDR_WIDTH=4: write 16-word packet without `wlast`, then 17th beat -> `full`=1, DISCARD; beats until `wlast` ignored; `drop_cnt`=1, `full`=0 after rollback.
- Fill and drain across wrap 5 times with 7-word packets at depth 16 -> data order preserved, `full`/`empty` correct at MSB wrap.
- `wen&&wlast&&wdrop` same cycle -> packet dropped, `empty`=1, count +1; `wdrop` in IDLE -> count unchanged.
- Assert `reset_n` low mid-read with committed data -> `rvalid`=0, `empty`=1, `level`=0 immediately, asynchronous to `clk`.
